// File: rtl/master_port.sv
// master_port: serializes one parallel read/write request onto single-bit
// address/data lines under valid/ready and collects serial read data back
// into a one-cycle parallel response, with a stall timeout abort.
module master_port #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  read_en,
  output logic                  write_en,
  output logic                  master_valid,
  input  logic                  slave_ready,
  output logic                  tx_address,
  output logic                  tx_data,
  input  logic                  slave_valid,
  output logic                  master_ready,
  input  logic                  rx_data
);

  localparam int unsigned CNT_W   = $clog2(ADDR_WIDTH + 1);
  localparam int unsigned STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic                  timeout_hit;

  logic                  resp_valid_d, resp_err_d, read_en_d, write_en_d;
  logic                  master_valid_d, master_ready_d, tx_address_d, tx_data_d;
  logic [DATA_WIDTH-1:0] resp_rdata_d;

  // Idle is the only state that can take a new request.
  assign req_ready = (state_q == IDLE);

  // Next-state, datapath and next-output decode; outputs follow the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    write_d     = write_q;
    err_d       = err_q;
    bit_cnt_d   = bit_cnt_q;
    stall_d     = stall_q;
    timeout_hit = (TIMEOUT != 0) && (stall_q == STALL_W'(TIMEOUT));

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_address;
          data_d    = req_write ? req_wdata : '0;
          write_d   = req_write;
          err_d     = 1'b0;
          rdata_d   = '0;
          bit_cnt_d = '0;
          stall_d   = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (slave_ready) begin
          addr_d  = {addr_q[ADDR_WIDTH-2:0], 1'b0};
          data_d  = {data_q[DATA_WIDTH-2:0], 1'b0};
          stall_d = '0;
          if (bit_cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = write_q ? RESP : RECV;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          stall_d   = '0;
          bit_cnt_d = '0;
          state_d   = RESP;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      RECV: begin
        if (slave_valid) begin
          rdata_d = {rdata_q[DATA_WIDTH-2:0], rx_data};
          stall_d = '0;
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = RESP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          stall_d   = '0;
          bit_cnt_d = '0;
          state_d   = RESP;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    master_valid_d = (state_d == SEND);
    master_ready_d = (state_d == RECV);
    write_en_d     = (state_d == SEND) && write_d;
    read_en_d      = ((state_d == SEND) && !write_d) || (state_d == RECV);
    tx_address_d   = (state_d == SEND) && addr_d[ADDR_WIDTH-1];
    tx_data_d      = (state_d == SEND) && data_d[DATA_WIDTH-1];
    resp_valid_d   = (state_d == RESP);
    resp_err_d     = (state_d == RESP) && err_d;
    resp_rdata_d   = ((state_d == RESP) && !err_d && !write_d) ? rdata_d : '0;
  end

  // State, shift registers, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      bit_cnt_q    <= '0;
      stall_q      <= '0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      read_en      <= 1'b0;
      write_en     <= 1'b0;
      master_valid <= 1'b0;
      master_ready <= 1'b0;
      tx_address   <= 1'b0;
      tx_data      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      write_q      <= write_d;
      err_q        <= err_d;
      bit_cnt_q    <= bit_cnt_d;
      stall_q      <= stall_d;
      resp_valid   <= resp_valid_d;
      resp_err     <= resp_err_d;
      resp_rdata   <= resp_rdata_d;
      read_en      <= read_en_d;
      write_en     <= write_en_d;
      master_valid <= master_valid_d;
      master_ready <= master_ready_d;
      tx_address   <= tx_address_d;
      tx_data      <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port (TIMEOUT reduced to 4 so the abort is reachable quickly).
module tb_master_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_address;
  logic [7:0]  req_wdata;
  logic        resp_valid, resp_err;
  logic [7:0]  resp_rdata;
  logic        read_en, write_en, master_valid, slave_ready;
  logic        tx_address, tx_data, slave_valid, master_ready, rx_data;

  int n_cmp = 0;
  int n_bad = 0;

  master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .read_en(read_en), .write_en(write_en), .master_valid(master_valid),
    .slave_ready(slave_ready), .tx_address(tx_address), .tx_data(tx_data),
    .slave_valid(slave_valid), .master_ready(master_ready), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " ctl"}, 32'({resp_valid, resp_err, read_en, write_en,
                              master_valid, master_ready, tx_address, tx_data}), 32'd0);
    check({tag, " rdata"}, 32'(resp_rdata), 32'd0);
  endtask

  // Present a request for one edge; afterwards we are in cycle T+1.
  task automatic issue(input logic wr, input logic [11:0] a, input logic [7:0] d);
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = a;
    req_wdata   = d;
    tick();
    req_valid   = 1'b0;
    req_address = 12'hFFF;
    req_wdata   = 8'hFF;
  endtask

  // From cycle T+1, expect an unstalled write of a/d and the response in T+13.
  task automatic serialize_write(input string tag, input logic [11:0] a, input logic [7:0] d);
    for (int k = 1; k <= 12; k++) begin
      check({tag, " tx_address"}, 32'(tx_address), 32'(a[12-k]));
      check({tag, " tx_data"}, 32'(tx_data), (k <= 8) ? 32'(d[8-k]) : 32'd0);
      check({tag, " wr/rd/mv"}, 32'({write_en, read_en, master_valid}), 32'b101);
      tick();
    end
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " resp_err"}, 32'(resp_err), 32'd0);
    check({tag, " resp ctl"}, 32'({write_en, master_valid, resp_rdata}), 32'd0);
    tick();
    check({tag, " req_ready T+14"}, 32'(req_ready), 32'd1);
    check({tag, " resp_valid T+14"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [11:0] a;
    logic [7:0]  d;
    logic [7:0]  rx;
    int          b;
    logic        sr;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = '0;
    slave_ready = 1'b1; slave_valid = 1'b0; rx_data = 1'b0;
    tick(); tick();
    check_idle("reset");
    reset = 1'b0;
    tick();
    check_idle("post reset");

    // Write, no stalls.
    issue(1'b1, 12'hA5C, 8'h3C);
    serialize_write("wr", 12'hA5C, 8'h3C);

    // Write with slave_ready low for three cycles after bit 4.
    a = 12'hA5C; d = 8'h3C; b = 0;
    issue(1'b1, a, d);
    for (int k = 1; k <= 15; k++) begin
      sr = !(k >= 6 && k <= 8);
      slave_ready = sr;
      check("stall tx_address", 32'(tx_address), 32'(a[11-b]));
      check("stall tx_data", 32'(tx_data), (b < 8) ? 32'(d[7-b]) : 32'd0);
      check("stall resp_valid", 32'(resp_valid), 32'd0);
      tick();
      if (sr) b++;
    end
    slave_ready = 1'b1;
    check("stall resp_valid T+16", 32'(resp_valid), 32'd1);
    check("stall resp_err", 32'(resp_err), 32'd0);
    tick();
    check_idle("stall done");

    // Read of 0x001 returning 0xCA.
    a = 12'h001; rx = 8'hCA;
    slave_valid = 1'b1;
    issue(1'b0, a, 8'h77);
    for (int k = 1; k <= 20; k++) begin
      if (k >= 13) rx_data = rx[7-(k-13)];
      check("rd tx_data", 32'(tx_data), 32'd0);
      check("rd read_en", 32'({read_en, write_en}), 32'b10);
      if (k <= 12) begin
        check("rd tx_address", 32'(tx_address), 32'(a[12-k]));
        check("rd send mr/mv", 32'({master_ready, master_valid}), 32'b01);
      end else begin
        check("rd recv mr/mv", 32'({master_ready, master_valid}), 32'b10);
      end
      tick();
    end
    slave_valid = 1'b0; rx_data = 1'b0;
    check("rd resp_valid T+21", 32'(resp_valid), 32'd1);
    check("rd resp_rdata", 32'(resp_rdata), 32'hCA);
    check("rd resp_err", 32'(resp_err), 32'd0);
    check("rd resp mr/re", 32'({master_ready, read_en}), 32'd0);
    tick();
    check_idle("rd done");

    // Read timeout: slave never returns data.
    issue(1'b0, 12'h0F0, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      check("to resp_valid", 32'(resp_valid), 32'd0);
      check("to master_ready", 32'(master_ready), (k >= 13) ? 32'd1 : 32'd0);
      tick();
    end
    check("to resp_valid", 32'(resp_valid), 32'd1);
    check("to resp_err", 32'(resp_err), 32'd1);
    check("to resp_rdata", 32'(resp_rdata), 32'd0);
    tick();
    check_idle("to done");

    // Reset while SEND shows bit 6.
    issue(1'b1, 12'hA5C, 8'h3C);
    for (int k = 1; k < 7; k++) tick();
    check("rst pre master_valid", 32'(master_valid), 32'd1);
    reset = 1'b1;
    tick();
    check_idle("rst held");
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle("rst after");
    end
    issue(1'b1, 12'h3C1, 8'h96);
    serialize_write("wr after rst", 12'h3C1, 8'h96);

    // Back-to-back writes with req_valid held.
    req_valid = 1'b1; req_write = 1'b1; req_address = 12'h123; req_wdata = 8'h55;
    tick();
    req_address = 12'h9E7; req_wdata = 8'hAA;
    a = 12'h123;
    for (int k = 1; k <= 13; k++) begin
      check("b2b req_ready", 32'(req_ready), 32'd0);
      if (k <= 12) check("b2b first tx_address", 32'(tx_address), 32'(a[12-k]));
      tick();
    end
    check("b2b req_ready T+14", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    serialize_write("b2b second", 12'h9E7, 8'hAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
